// File: rtl/ldd_seq_ctrl.sv
// Multi-channel LDD power sequencer: ordered OSCEA->DISEA->OUTEA ramp-up, reverse ramp-down,
// synchronised fault shutdown latched until cleared. Optional watchdog enabled by LDD_WDOG_EN.
module ldd_seq_ctrl #(
  parameter int CH_NUM   = 2,
  parameter int TMR_W    = 16,
  parameter int T_OSC    = 1250,
  parameter int T_DIS    = 1250,
  parameter int T_OUT    = 125,
  parameter int WDOG_W   = 24,
  parameter int WDOG_LIM = 12500000
) (
  input  logic                  clk125,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     cmd_en,
  input  logic [CH_NUM-1:0]     cmd_clr,
  input  logic [CH_NUM-1:0]     rdis_req,
  input  logic [CH_NUM-1:0]     ldd_fault,
  input  logic                  wdog_kick,
  output logic [CH_NUM-1:0]     ldd_oscea,
  output logic [CH_NUM-1:0]     ldd_disea,
  output logic [CH_NUM-1:0]     ldd_outea,
  output logic [CH_NUM-1:0]     ldd_rdisn,
  output logic [3*CH_NUM-1:0]   sts_state,
  output logic [CH_NUM-1:0]     sts_on,
  output logic [CH_NUM-1:0]     sts_fault,
  output logic                  sts_wdog
);

  localparam logic [2:0] S_OFF     = 3'd0;
  localparam logic [2:0] S_PRE_OSC = 3'd1;
  localparam logic [2:0] S_PRE_DIS = 3'd2;
  localparam logic [2:0] S_ON      = 3'd3;
  localparam logic [2:0] S_RAMP_DN = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  localparam logic [TMR_W-1:0] T_OSC_LAST = TMR_W'(T_OSC - 1);
  localparam logic [TMR_W-1:0] T_DIS_LAST = TMR_W'(T_DIS - 1);
  localparam logic [TMR_W-1:0] T_OUT_LAST = TMR_W'(T_OUT - 1);

  logic [CH_NUM-1:0] fault_meta_q;
  logic [CH_NUM-1:0] fault_sync_q;
  logic [CH_NUM-1:0] ch_active;
  logic              wdog_trip;

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      fault_meta_q <= '0;
      fault_sync_q <= '0;
    end else begin
      fault_meta_q <= ldd_fault;
      fault_sync_q <= fault_meta_q;
    end
  end

`ifdef LDD_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              sts_wdog_q, sts_wdog_d;

  assign wdog_trip = (wdog_cnt_q == WDOG_W'(WDOG_LIM));

  // Counter is held at zero while no channel is sequencing, so a fresh power-up starts a full period.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (wdog_kick || !(|ch_active))
      wdog_cnt_d = '0;
    else if (!wdog_trip)
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    sts_wdog_d = sts_wdog_q;
    if (wdog_trip)
      sts_wdog_d = 1'b1;
    else if (|cmd_clr)
      sts_wdog_d = 1'b0;
  end

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q <= '0;
      sts_wdog_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      sts_wdog_q <= sts_wdog_d;
    end
  end

  assign sts_wdog = sts_wdog_q;
`else
  logic wdog_unused;
  assign wdog_unused = wdog_kick | (|ch_active);
  assign wdog_trip   = 1'b0;
  assign sts_wdog    = 1'b0;
`endif

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             oscea_q, oscea_d;
    logic             disea_q, disea_d;
    logic             outea_q, outea_d;
    logic             rdisn_q, rdisn_d;
    logic             go_fault;

    // A watchdog trip catches every channel that is not idle.
    assign go_fault = fault_sync_q[gi] | (wdog_trip & (state_q != S_OFF));

    always_comb begin
      state_d = state_q;
      case (state_q)
        S_OFF: begin
          if (go_fault)          state_d = S_FAULT;
          else if (cmd_en[gi])   state_d = S_PRE_OSC;
        end
        S_PRE_OSC: begin
          if (go_fault)                  state_d = S_FAULT;
          else if (!cmd_en[gi])          state_d = S_OFF;
          else if (timer_q == T_OSC_LAST) state_d = S_PRE_DIS;
        end
        S_PRE_DIS: begin
          if (go_fault)                  state_d = S_FAULT;
          else if (!cmd_en[gi])          state_d = S_OFF;
          else if (timer_q == T_DIS_LAST) state_d = S_ON;
        end
        S_ON: begin
          if (go_fault)          state_d = S_FAULT;
          else if (!cmd_en[gi])  state_d = S_RAMP_DN;
        end
        S_RAMP_DN: begin
          if (go_fault)                  state_d = S_FAULT;
          else if (timer_q == T_OUT_LAST) state_d = S_OFF;
        end
        S_FAULT: begin
          if (cmd_clr[gi] && !cmd_en[gi] && !fault_sync_q[gi]) state_d = S_OFF;
        end
        default: state_d = S_OFF;
      endcase
    end

    // Outputs are decoded from the next state so they change on the same edge the state does.
    always_comb begin
      oscea_d = (state_d == S_PRE_OSC) || (state_d == S_PRE_DIS) ||
                (state_d == S_ON) || (state_d == S_RAMP_DN);
      disea_d = (state_d == S_PRE_DIS) || (state_d == S_ON) || (state_d == S_RAMP_DN);
      outea_d = (state_d == S_ON);
      rdisn_d = (state_d == S_FAULT) ? 1'b0 : ~rdis_req[gi];
      if ((state_d != state_q) || (state_d == S_OFF) || (state_d == S_ON) || (state_d == S_FAULT))
        timer_d = '0;
      else
        timer_d = timer_q + 1'b1;
    end

    always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
        state_q <= S_OFF;
        timer_q <= '0;
        oscea_q <= 1'b0;
        disea_q <= 1'b0;
        outea_q <= 1'b0;
        rdisn_q <= 1'b0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        oscea_q <= oscea_d;
        disea_q <= disea_d;
        outea_q <= outea_d;
        rdisn_q <= rdisn_d;
      end
    end

    assign ldd_oscea[gi]         = oscea_q;
    assign ldd_disea[gi]         = disea_q;
    assign ldd_outea[gi]         = outea_q;
    assign ldd_rdisn[gi]         = rdisn_q;
    assign sts_state[3*gi +: 3]  = state_q;
    assign sts_on[gi]            = (state_q == S_ON);
    assign sts_fault[gi]         = (state_q == S_FAULT);
    assign ch_active[gi]         = (state_q != S_OFF) && (state_q != S_FAULT);
  end

endmodule

// File: tb/tb_ldd_seq_ctrl.sv
// Bench for ldd_seq_ctrl: directed sequencing scenarios plus random traffic against a behavioural model.
module tb_ldd_seq_ctrl;
  localparam int CH = 2;
  localparam int TO = 4;
  localparam int TD = 3;
  localparam int TU = 2;
  localparam int WL = 50;

  logic          clk125 = 1'b0;
  logic          rst;
  logic [CH-1:0] cmd_en, cmd_clr, rdis_req, ldd_fault;
  logic          wdog_kick;
  logic [CH-1:0] ldd_oscea, ldd_disea, ldd_outea, ldd_rdisn;
  logic [3*CH-1:0] sts_state;
  logic [CH-1:0] sts_on, sts_fault;
  logic          sts_wdog;

  int checks = 0;
  int failures = 0;

  ldd_seq_ctrl #(.CH_NUM(CH), .TMR_W(16), .T_OSC(TO), .T_DIS(TD), .T_OUT(TU),
                 .WDOG_W(24), .WDOG_LIM(WL)) dut (
    .clk125(clk125), .rst(rst), .cmd_en(cmd_en), .cmd_clr(cmd_clr),
    .rdis_req(rdis_req), .ldd_fault(ldd_fault), .wdog_kick(wdog_kick),
    .ldd_oscea(ldd_oscea), .ldd_disea(ldd_disea), .ldd_outea(ldd_outea),
    .ldd_rdisn(ldd_rdisn), .sts_state(sts_state), .sts_on(sts_on),
    .sts_fault(sts_fault), .sts_wdog(sts_wdog)
  );

  always #4 clk125 = ~clk125;

  // Reference model: phase name, cycles spent in it, and the fault as seen after two clock stages.
  typedef enum int {P_OFF = 0, P_OSC = 1, P_DIS = 2, P_ON = 3, P_RAMP = 4, P_FLT = 5} phase_t;
  phase_t m_ph[CH];
  int     m_age[CH];
  bit     m_f1[CH], m_f2[CH];
  bit     m_rdisn[CH];
  bit     m_chk = 1'b1;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ph[c] = P_OFF; m_age[c] = 0; m_f1[c] = 0; m_f2[c] = 0; m_rdisn[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      phase_t nx;
      bit f, en;
      f  = m_f2[c];
      en = cmd_en[c];
      nx = m_ph[c];
      if (m_ph[c] == P_FLT) begin
        if (cmd_clr[c] && !en && !f) nx = P_OFF;
      end else if (f) begin
        nx = P_FLT;
      end else begin
        case (m_ph[c])
          P_OFF:  if (en) nx = P_OSC;
          P_OSC:  if (!en) nx = P_OFF; else if (m_age[c] + 1 == TO) nx = P_DIS;
          P_DIS:  if (!en) nx = P_OFF; else if (m_age[c] + 1 == TD) nx = P_ON;
          P_ON:   if (!en) nx = P_RAMP;
          P_RAMP: if (m_age[c] + 1 == TU) nx = P_OFF;
          default: nx = P_OFF;
        endcase
      end
      m_age[c]   = (nx == m_ph[c]) ? m_age[c] + 1 : 0;
      m_ph[c]    = nx;
      m_rdisn[c] = (nx == P_FLT) ? 1'b0 : !rdis_req[c];
      m_f2[c]    = m_f1[c];
      m_f1[c]    = ldd_fault[c];
    end
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d t=%0t", tag, c, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    for (int c = 0; c < CH; c++) begin
      int p;
      p = int'(m_ph[c]);
      chk("state", c, 32'(sts_state[3*c +: 3]), p);
      chk("oscea", c, 32'(ldd_oscea[c]), 32'(p >= 1 && p <= 4));
      chk("disea", c, 32'(ldd_disea[c]), 32'(p >= 2 && p <= 4));
      chk("outea", c, 32'(ldd_outea[c]), 32'(p == 3));
      chk("rdisn", c, 32'(ldd_rdisn[c]), 32'(m_rdisn[c]));
      chk("sts_on", c, 32'(sts_on[c]), 32'(p == 3));
      chk("sts_fault", c, 32'(sts_fault[c]), 32'(p == 5));
    end
    chk("sts_wdog", 0, 32'(sts_wdog), 0);
  endtask

  task automatic step();
    @(posedge clk125);
    model_edge();
    #1;
    if (m_chk) compare_model();
    @(negedge clk125);
  endtask

  initial begin
    rst = 1'b0; cmd_en = '0; cmd_clr = '0; rdis_req = '0; ldd_fault = '0;
`ifdef LDD_WDOG_EN
    wdog_kick = 1'b1;
`else
    wdog_kick = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk125);
    chk("rst_oscea", 0, 32'(ldd_oscea), 0);
    chk("rst_outea", 0, 32'(ldd_outea), 0);
    chk("rst_rdisn", 0, 32'(ldd_rdisn), 0);
    chk("rst_state", 0, 32'(sts_state), 0);
    chk("rst_wdog", 0, 32'(sts_wdog), 0);
    rst = 1'b1;

    // Power-up of channel 0 with exact dwell edges.
    cmd_en[0] = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      if (e == 0) begin chk("pu_osc_e0", 0, 32'(ldd_oscea[0]), 1); chk("pu_dis_e0", 0, 32'(ldd_disea[0]), 0); end
      if (e == 3) chk("pu_dis_e3", 0, 32'(ldd_disea[0]), 0);
      if (e == 4) chk("pu_dis_e4", 0, 32'(ldd_disea[0]), 1);
      if (e == 6) chk("pu_out_e6", 0, 32'(ldd_outea[0]), 0);
      if (e == 7) begin chk("pu_out_e7", 0, 32'(ldd_outea[0]), 1); chk("pu_state_e7", 0, 32'(sts_state[2:0]), 3); end
    end
    chk("pu_ch1_idle", 1, 32'(ldd_oscea[1]), 0);

    // Ramp-down.
    cmd_en[0] = 1'b0;
    step(); chk("rd_out_k", 0, 32'(ldd_outea[0]), 0); chk("rd_osc_k", 0, 32'(ldd_oscea[0]), 1);
    step(); chk("rd_osc_k1", 0, 32'(ldd_oscea[0]), 1);
    step(); chk("rd_osc_k2", 0, 32'(ldd_oscea[0]), 0); chk("rd_state_k2", 0, 32'(sts_state[2:0]), 0);

    // Abort in PRE_OSC on channel 1.
    cmd_en[1] = 1'b1;
    step(); step();
    cmd_en[1] = 1'b0;
    step(); chk("ab_osc", 1, 32'(ldd_oscea[1]), 0); chk("ab_state", 1, 32'(sts_state[5:3]), 0);

    // Fault from ON, latch, and clear rules.
    cmd_en[0] = 1'b1;
    repeat (8) step();
    ldd_fault[0] = 1'b1;
    step(); step(); chk("flt_not_yet", 0, 32'(sts_fault[0]), 0);
    step(); chk("flt_k3", 0, 32'(sts_fault[0]), 1); chk("flt_osc", 0, 32'(ldd_oscea[0]), 0);
    chk("flt_rdisn", 0, 32'(ldd_rdisn[0]), 0);
    cmd_clr[0] = 1'b1; step(); cmd_clr[0] = 1'b0;
    chk("flt_clr_en1", 0, 32'(sts_fault[0]), 1);
    ldd_fault[0] = 1'b0; cmd_en[0] = 1'b0;
    repeat (3) step();
    cmd_clr[0] = 1'b1; step(); cmd_clr[0] = 1'b0;
    chk("flt_cleared", 0, 32'(sts_state[2:0]), 0);

    // Fault arriving on the same edge the PRE_DIS dwell expires.
    cmd_en[0] = 1'b1;
    repeat (5) step();
    ldd_fault[0] = 1'b1;
    step(); step(); chk("sim_predis", 0, 32'(sts_state[2:0]), 2);
    step(); chk("sim_fault", 0, 32'(sts_state[2:0]), 5); chk("sim_outea", 0, 32'(ldd_outea[0]), 0);
    ldd_fault[0] = 1'b0; cmd_en[0] = 1'b0;
    repeat (3) step();
    cmd_clr[0] = 1'b1; step(); cmd_clr[0] = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) cmd_en[c] = ~cmd_en[c];
        if ($urandom_range(0, 29) == 0) ldd_fault[c] = ~ldd_fault[c];
        if ($urandom_range(0, 15) == 0) rdis_req[c] = ~rdis_req[c];
        cmd_clr[c] = ($urandom_range(0, 7) == 0);
      end
`ifndef LDD_WDOG_EN
      wdog_kick = 1'($urandom_range(0, 1));
`endif
      step();
    end

    // Asynchronous reset in the middle of ON.
    cmd_en = '0; ldd_fault = '0; cmd_clr = '0; rdis_req = '0;
    repeat (4) step();
    cmd_clr = '1; step(); cmd_clr = '0; step();
    cmd_en = '1;
    repeat (8) step();
    chk("both_on", 0, 32'(sts_on), 3);
    #2 rst = 1'b0;
    #1;
    chk("arst_osc", 0, 32'(ldd_oscea), 0);
    chk("arst_out", 0, 32'(ldd_outea), 0);
    chk("arst_rdisn", 0, 32'(ldd_rdisn), 0);
    chk("arst_state", 0, 32'(sts_state), 0);
    model_reset();
    @(negedge clk125);
    rst = 1'b1;
    repeat (8) step();

    // Watchdog behaviour.
`ifdef LDD_WDOG_EN
    m_chk = 1'b0;
    for (int n = 0; n < 120; n++) begin
      wdog_kick = (n % 40 == 39);
      step();
    end
    chk("wd_kept_on", 0, 32'(sts_on), 3);
    wdog_kick = 1'b0;
    repeat (60) step();
    chk("wd_fault", 0, 32'(sts_fault), 3);
    chk("wd_flag", 0, 32'(sts_wdog), 1);
    cmd_en = '0; cmd_clr = '1; step(); cmd_clr = '0;
    chk("wd_flag_clr", 0, 32'(sts_wdog), 0);
`else
    wdog_kick = 1'b0;
    repeat (1000) step();
    chk("nowd_on", 0, 32'(sts_on), 3);
    chk("nowd_flag", 0, 32'(sts_wdog), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
